data_mem_responder: RTL and testbench

//  Memory-side responder for the processor's load/store port: accepts one request at a

---
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Slow data-memory responder: one request at a time on a valid/ready channel,
// WAIT_CYCLES wait states, then a load-data or store-ack response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [63:0] lat_addr, lat_wdata;
    logic [7:0]  lat_wstrb;
    logic [63:0] mem [DEPTH_WORDS];

    logic             accept, commit;
    logic             c_write, c_err;
    logic [63:0]      c_addr, c_wdata;
    logic [7:0]       c_wstrb;
    logic [60:0]      c_word;
    logic [IDX_W-1:0] c_idx;

    assign req_ready = (state == IDLE) && reset_n;
    assign rsp_valid = (state == RESP);
    assign accept    = (state == IDLE) && req_valid;
    assign commit    = ((state == BUSY) && (cnt == 4'd0)) || (accept && ZERO_WAIT);

    // With zero wait states the commit happens on the accept edge itself, so the
    // live request inputs are used instead of the not-yet-latched copies.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        c_write = lat_write;
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_wstrb = lat_wstrb;
        if (state == IDLE) begin
            c_write = req_write;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_wstrb = req_wstrb;
        end
        c_word = c_addr[63:3];
        c_idx  = c_word[IDX_W-1:0];
        c_err  = (c_addr[2:0] != 3'd0) || (c_word >= 61'(DEPTH_WORDS));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ZERO_WAIT ? RESP : BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= 64'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= WAIT_INIT;
            else if ((state == BUSY) && (cnt != 4'd0))
                cnt <= cnt - 4'd1;
            if (commit) begin
                rsp_err   <= c_err;
                rsp_rdata <= (!c_write && !c_err) ? mem[c_idx] : 64'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    // NOTE: the storage array has no reset; contents survive reset_n, and only the
    // commit is gated by it so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (reset_n && commit && c_write && !c_err) begin
            for (int b = 0; b < 8; b++) begin
                if (c_wstrb[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: two responders (2 wait states and 0 wait states) driven through
// the same scenario tasks, index d selects the instance.
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [63:0] req_addr  [2];
    logic [63:0] req_wdata [2];
    logic [7:0]  req_wstrb [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [63:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic drive_req(input int d, input logic wr, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] strb);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wstrb[d] = strb;
    endtask

    // Waits for req_ready, accepts at the next posedge, scrambles the inputs, then
    // counts negedges until rsp_valid and completes the handshake (rsp_ready high).
    task automatic do_req(input int d, input logic wr, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          output logic [63:0] rdata, output logic err,
                          output int lat, output int acc);
        int n;
        @(negedge clk);
        drive_req(d, wr, addr, wdata, strb);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin bad++; $display("FAIL d%0d accept_timeout got=%0d want<50", d, n); end
        acc = cyc;
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = '1;
        req_wdata[d] = '1;
        req_wstrb[d] = '1;
        req_write[d] = ~wr;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat >= 50) begin bad++; $display("FAIL d%0d rsp_timeout got=%0d want<50", d, lat); end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_ready[d] !== 1'b0) begin bad++; $display("FAIL d%0d ready_in_reset got=%b want=0", d, req_ready[d]); end
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL d%0d reset_ready got=%b want=1", d, req_ready[d]); end
            total++;
            if (rsp_valid[d] !== 1'b0) begin bad++; $display("FAIL d%0d reset_valid got=%b want=0", d, rsp_valid[d]); end
            total++;
            if (rsp_rdata[d] !== 64'd0) begin bad++; $display("FAIL d%0d reset_rdata got=%h want=0", d, rsp_rdata[d]); end
            total++;
            if (rsp_err[d] !== 1'b0) begin bad++; $display("FAIL d%0d reset_err got=%b want=0", d, rsp_err[d]); end
        end
    endtask

    task automatic test_store_load(input int d);
        logic [63:0] rd;
        logic        er;
        int          lat, acc;
        do_req(d, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, rd, er, lat, acc);
        total++;
        if (lat !== wait_of(d) + 1) begin bad++; $display("FAIL d%0d store_latency got=%0d want=%0d", d, lat, wait_of(d) + 1); end
        total++;
        if (er !== 1'b0 || rd !== 64'd0) begin bad++; $display("FAIL d%0d store_ack got=%b/%h want=0/0", d, er, rd); end
        @(negedge clk);
        total++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            bad++; $display("FAIL d%0d after_handshake got=valid%b/ready%b want=0/1", d, rsp_valid[d], req_ready[d]);
        end
        do_req(d, 1'b0, 64'h10, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (lat !== wait_of(d) + 1) begin bad++; $display("FAIL d%0d load_latency got=%0d want=%0d", d, lat, wait_of(d) + 1); end
        total++;
        if (er !== 1'b0 || rd !== 64'hDEADBEEF_CAFEF00D) begin
            bad++; $display("FAIL d%0d load_full got=%b/%h want=0/deadbeefcafef00d", d, er, rd);
        end
    endtask

    task automatic test_partial(input int d);
        logic [63:0] rd;
        logic        er;
        int          lat, acc;
        do_req(d, 1'b1, 64'h10, 64'h11111111_22222222, 8'h0F, rd, er, lat, acc);
        do_req(d, 1'b0, 64'h10, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (er !== 1'b0 || rd !== 64'hDEADBEEF_22222222) begin
            bad++; $display("FAIL d%0d partial_store got=%b/%h want=0/deadbeef22222222", d, er, rd);
        end
    endtask

    task automatic test_errors(input int d);
        logic [63:0] rd;
        logic        er;
        int          lat, acc;
        do_req(d, 1'b0, 64'h13, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (er !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL d%0d misaligned_load got=%b/%h want=1/0", d, er, rd); end
        do_req(d, 1'b1, 64'h0, 64'h01234567_89ABCDEF, 8'hFF, rd, er, lat, acc);
        // Out-of-range word aliases onto word 0 if the range check were dropped.
        do_req(d, 1'b1, 64'(8 * DEPTH), 64'hFFFFFFFF_FFFFFFFF, 8'hFF, rd, er, lat, acc);
        total++;
        if (er !== 1'b1 || rd !== 64'd0) begin bad++; $display("FAIL d%0d range_store got=%b/%h want=1/0", d, er, rd); end
        do_req(d, 1'b0, 64'h0, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (er !== 1'b0 || rd !== 64'h01234567_89ABCDEF) begin
            bad++; $display("FAIL d%0d range_nowrite got=%b/%h want=0/0123456789abcdef", d, er, rd);
        end
        do_req(d, 1'b1, 64'h10, 64'h99999999_99999999, 8'h00, rd, er, lat, acc);
        total++;
        if (er !== 1'b0 || rd !== 64'd0) begin bad++; $display("FAIL d%0d zero_strb_ack got=%b/%h want=0/0", d, er, rd); end
        do_req(d, 1'b0, 64'h10, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (rd !== 64'hDEADBEEF_22222222) begin bad++; $display("FAIL d%0d zero_strb_data got=%h want=deadbeef22222222", d, rd); end
    endtask

    task automatic test_backpressure(input int d);
        logic [63:0] rd;
        logic        er;
        int          n, lat, acc;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        drive_req(d, 1'b0, 64'h10, 64'd0, 8'h00);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        drive_req(d, 1'b1, 64'h10, 64'h55555555_55555555, 8'hFF);
        n = 0;
        while (rsp_valid[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL d%0d bp_timeout got=%0d want<50", d, n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== 64'hDEADBEEF_22222222 || req_ready[d] !== 1'b0) begin
                bad++;
                $display("FAIL d%0d bp_hold%0d got=valid%b/%h/ready%b want=1/deadbeef22222222/0",
                         d, i, rsp_valid[d], rsp_rdata[d], req_ready[d]);
            end
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            bad++; $display("FAIL d%0d bp_release got=valid%b/ready%b want=0/1", d, rsp_valid[d], req_ready[d]);
        end
        do_req(d, 1'b0, 64'h10, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (rd !== 64'hDEADBEEF_22222222) begin bad++; $display("FAIL d%0d bp_no_accept got=%h want=deadbeef22222222", d, rd); end
    endtask

    task automatic test_back_to_back(input int d);
        logic [63:0] rd;
        logic        er;
        int          lat, acc0, acc1;
        do_req(d, 1'b0, 64'h0, 64'd0, 8'h00, rd, er, lat, acc0);
        do_req(d, 1'b0, 64'h10, 64'd0, 8'h00, rd, er, lat, acc1);
        total++;
        if (acc1 - acc0 !== wait_of(d) + 2) begin
            bad++; $display("FAIL d%0d b2b_spacing got=%0d want=%0d", d, acc1 - acc0, wait_of(d) + 2);
        end
        total++;
        if (rd !== 64'hDEADBEEF_22222222) begin bad++; $display("FAIL d%0d b2b_data got=%h want=deadbeef22222222", d, rd); end
    endtask

    task automatic test_reset_mid(input int d);
        logic [63:0] rd, want;
        logic        er;
        int          n, lat, acc;
        do_req(d, 1'b1, 64'h20, 64'hAAAAAAAA_AAAAAAAA, 8'hFF, rd, er, lat, acc);
        @(negedge clk);
        drive_req(d, 1'b1, 64'h20, 64'hBBBBBBBB_BBBBBBBB, 8'hFF);
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid[d] = 1'b0;
        reset_n      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b0) begin
            bad++; $display("FAIL d%0d mid_reset got=valid%b/ready%b want=0/0", d, rsp_valid[d], req_ready[d]);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (req_ready[d] !== 1'b1) begin bad++; $display("FAIL d%0d mid_reset_ready got=%b want=1", d, req_ready[d]); end
        // Without wait states the store commits on its accept edge, before the reset.
        want = (wait_of(d) == 0) ? 64'hBBBBBBBB_BBBBBBBB : 64'hAAAAAAAA_AAAAAAAA;
        do_req(d, 1'b0, 64'h20, 64'd0, 8'h00, rd, er, lat, acc);
        total++;
        if (er !== 1'b0 || rd !== want) begin bad++; $display("FAIL d%0d mid_reset_data got=%b/%h want=0/%h", d, er, rd, want); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 64'd0;
            req_wdata[d] = 64'd0;
            req_wstrb[d] = 8'd0;
            rsp_ready[d] = 1'b1;
        end
        reset_n = 1'b0;
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_store_load(d);
            test_partial(d);
            test_errors(d);
            test_backpressure(d);
            test_back_to_back(d);
            test_reset_mid(d);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
